// File: rtl/ysyx_25070198_mem_pkg.sv
// Shared types for the IFU/LSU memory-port arbiter.
package ysyx_25070198_mem_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0]   addr;
    logic                    wen;
    logic [MEM_DATA_W-1:0]   wdata;
    logic [MEM_DATA_W/8-1:0] wmask;
  } req_t;

endpackage

// File: rtl/ysyx_25070198_rr_arb2.sv
// Two-input round-robin grant; on a tie the requester that did not win last time wins.
module ysyx_25070198_rr_arb2
  import ysyx_25070198_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  owner_t last_q, last_d;

  always_comb begin
    gnt_o[0] = en_i & req_i[0] & (~req_i[1] | (last_q == OWN_LSU));
    gnt_o[1] = en_i & req_i[1] & (~req_i[0] | (last_q == OWN_IFU));
    last_d   = last_q;
    if (|gnt_o) last_d = gnt_o[1] ? OWN_LSU : OWN_IFU;
  end

  // Starting at LSU makes the first contest after reset go to IFU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= OWN_LSU;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/ysyx_25070198_mem_arb.sv
// Shares one memory port between IFU and LSU with a single transaction in flight,
// and turns a missing response into an error response after TIMEOUT cycles.
module ysyx_25070198_mem_arb
  import ysyx_25070198_mem_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_resp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp_err
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  arb_state_t       state_q, state_d;
  owner_t           owner_q, owner_d;
  req_t             req_q, req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       gnt;
  logic             tmo_hit;
  logic             resp_valid;
  logic             resp_err;
  logic [DATA_W-1:0] resp_data;

  // Grants are suppressed while rst is held so every output reads 0 during reset.
  ysyx_25070198_rr_arb2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .en_i  ((state_q == IDLE) & ~rst),
    .req_i ({lsu_req_valid, ifu_req_valid}),
    .gnt_o (gnt)
  );

  assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    req_d      = req_q;
    cnt_d      = cnt_q;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_data  = '0;
    case (state_q)
      IDLE: begin
        if (gnt[0]) begin
          req_d   = '{addr: ifu_addr, wen: 1'b0, wdata: '0, wmask: '0};
          owner_d = OWN_IFU;
          state_d = REQ;
        end else if (gnt[1]) begin
          req_d   = '{addr: lsu_addr, wen: lsu_wen, wdata: lsu_wdata, wmask: lsu_wmask};
          owner_d = OWN_LSU;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_resp_valid) begin
          resp_valid = 1'b1;
          resp_err   = mem_resp_err;
          resp_data  = mem_rdata;
          state_d    = IDLE;
        end else if (tmo_hit) begin
          resp_valid = 1'b1;
          resp_err   = 1'b1;
          cnt_d      = '0;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_resp_valid || tmo_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_IFU;
      req_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ifu_req_ready  = gnt[0];
  assign lsu_req_ready  = gnt[1];

  assign mem_req_valid  = (state_q == REQ);
  assign mem_addr       = req_q.addr;
  assign mem_wen        = req_q.wen;
  assign mem_wdata      = req_q.wdata;
  assign mem_wmask      = req_q.wmask;

  assign ifu_resp_valid = resp_valid & (owner_q == OWN_IFU);
  assign ifu_resp_err   = resp_err   & (owner_q == OWN_IFU);
  assign ifu_rdata      = (owner_q == OWN_IFU) ? resp_data : '0;
  assign lsu_resp_valid = resp_valid & (owner_q == OWN_LSU);
  assign lsu_resp_err   = resp_err   & (owner_q == OWN_LSU);
  assign lsu_rdata      = (owner_q == OWN_LSU) ? resp_data : '0;

endmodule

// File: tb/tb_ysyx_25070198_mem_arb.sv
// Directed bench for the IFU/LSU memory arbiter (built with TIMEOUT=4).
module tb_ysyx_25070198_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid, ifu_resp_err;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_resp_valid, lsu_resp_err;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid, mem_req_ready, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid, mem_resp_err;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_25070198_mem_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1003;
    lsu_wen = 1'b1; lsu_wdata = 32'h0000_000F; lsu_wmask = 4'b1000;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF; mem_resp_err = 1'b1;
    #1;
    chk("rst_ifu_ready", {31'd0, ifu_req_ready}, 32'd0);
    chk("rst_lsu_ready", {31'd0, lsu_req_ready}, 32'd0);
    chk("rst_mem_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_ifu_resp", {31'd0, ifu_resp_valid}, 32'd0);
    chk("rst_ifu_rdata", ifu_rdata, 32'd0);
    step();
    step();

    // Both valid from reset: IFU first, then LSU write through a 3-cycle stall.
    rst = 1'b0; mem_resp_valid = 1'b0; mem_resp_err = 1'b0; mem_rdata = 32'd0;
    #1;
    chk("t2_ifu_ready", {31'd0, ifu_req_ready}, 32'd1);
    chk("t2_lsu_ready", {31'd0, lsu_req_ready}, 32'd0);
    step();
    chk("t2_req_ifu_wen", {31'd0, mem_wen}, 32'd0);
    chk("t2_req_ifu_addr", mem_addr, 32'h8000_0000);
    chk("t2_req_lsu_ready", {31'd0, lsu_req_ready}, 32'd0);
    step();
    mem_resp_valid = 1'b1; mem_rdata = 32'h1111_2222; #1;
    chk("t2_ifu_resp", {31'd0, ifu_resp_valid}, 32'd1);
    step();
    mem_resp_valid = 1'b0; mem_req_ready = 1'b0; #1;
    chk("t2_lsu_win", {31'd0, lsu_req_ready}, 32'd1);
    chk("t2_ifu_lose", {31'd0, ifu_req_ready}, 32'd0);
    step();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wmask = 4'h0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("t2_stall_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("t2_stall_addr", mem_addr, 32'h8000_1003);
      chk("t2_stall_wen", {31'd0, mem_wen}, 32'd1);
      chk("t2_stall_mask", {28'd0, mem_wmask}, 32'h8);
      chk("t2_stall_wdata", mem_wdata, 32'h0000_000F);
      step();
    end
    mem_req_ready = 1'b1; #1;
    chk("t2_hs_valid", {31'd0, mem_req_valid}, 32'd1);
    step();
    mem_resp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
    chk("t2_lsu_resp", {31'd0, lsu_resp_valid}, 32'd1);
    chk("t2_lsu_rdata", lsu_rdata, 32'hDEAD_BEEF);
    chk("t2_ifu_quiet", {31'd0, ifu_resp_valid}, 32'd0);
    step();
    mem_resp_valid = 1'b0;

    // Six back-to-back contests alternate starting with IFU.
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_2000;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t3_ifu_ready", {31'd0, ifu_req_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t3_lsu_ready", {31'd0, lsu_req_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      step();
      chk("t3_mem_wen", {31'd0, mem_wen}, (i % 2 == 1) ? 32'd1 : 32'd0);
      step();
      mem_resp_valid = 1'b1; mem_rdata = 32'(i); #1;
      chk("t3_ifu_resp", {31'd0, ifu_resp_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t3_lsu_resp", {31'd0, lsu_resp_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
      step();
      mem_resp_valid = 1'b0;
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; lsu_wen = 1'b0;

    // IFU-only read with zero-wait memory: response two cycles after accept.
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; #1;
    chk("t1_accept", {31'd0, ifu_req_ready}, 32'd1);
    step();
    ifu_req_valid = 1'b0; #1;
    chk("t1_mem_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h8000_0000);
    step();
    mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0413; #1;
    chk("t1_ifu_resp", {31'd0, ifu_resp_valid}, 32'd1);
    chk("t1_ifu_rdata", ifu_rdata, 32'h0000_0413);
    chk("t1_lsu_quiet", {31'd0, lsu_resp_valid}, 32'd0);
    step();
    mem_resp_valid = 1'b0; #1;
    chk("t1_pulse_end", {31'd0, ifu_resp_valid}, 32'd0);

    // Memory error on an IFU read.
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004; #1;
    step();
    ifu_req_valid = 1'b0;
    step();
    mem_resp_valid = 1'b1; mem_resp_err = 1'b1; mem_rdata = 32'h0; #1;
    chk("t6_err_valid", {31'd0, ifu_resp_valid}, 32'd1);
    chk("t6_err", {31'd0, ifu_resp_err}, 32'd1);
    step();
    mem_resp_valid = 1'b0; mem_resp_err = 1'b0; #1;
    chk("t6_err_end", {31'd0, ifu_resp_err}, 32'd0);
    chk("t6_valid_end", {31'd0, ifu_resp_valid}, 32'd0);

    // LSU read with no response: timeout error in the 4th WAIT cycle, late response dropped.
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_3000; #1;
    chk("t4_idle_grant", {31'd0, lsu_req_ready}, 32'd1);
    step();
    lsu_req_valid = 1'b0; mem_rdata = 32'h1234_5678;
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_wait_quiet", {31'd0, lsu_resp_valid}, 32'd0);
      step();
    end
    #1;
    chk("t4_tmo_valid", {31'd0, lsu_resp_valid}, 32'd1);
    chk("t4_tmo_err", {31'd0, lsu_resp_err}, 32'd1);
    chk("t4_tmo_rdata", lsu_rdata, 32'd0);
    chk("t4_tmo_ifu", {31'd0, ifu_resp_valid}, 32'd0);
    step();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100; #1;
    chk("t4_drain_nogrant", {31'd0, ifu_req_ready}, 32'd0);
    chk("t4_drain_quiet", {31'd0, lsu_resp_valid}, 32'd0);
    step();
    mem_resp_valid = 1'b1; #1;
    chk("t4_late_lsu", {31'd0, lsu_resp_valid}, 32'd0);
    chk("t4_late_ifu", {31'd0, ifu_resp_valid}, 32'd0);
    step();
    mem_resp_valid = 1'b0; #1;
    chk("t4_after_grant", {31'd0, ifu_req_ready}, 32'd1);
    step();
    ifu_req_valid = 1'b0; #1;
    chk("t4_after_addr", mem_addr, 32'h8000_0100);
    step();
    mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_0001; #1;
    chk("t4_after_resp", ifu_rdata, 32'hCAFE_0001);
    step();
    mem_resp_valid = 1'b0;

    // Reset in WAIT aborts silently; next IFU request is served normally.
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0200; #1;
    step();
    step();
    rst = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'hBBBB_0000; #1;
    chk("t5_rst_resp", {31'd0, ifu_resp_valid}, 32'd0);
    chk("t5_rst_ready", {31'd0, ifu_req_ready}, 32'd0);
    chk("t5_rst_memv", {31'd0, mem_req_valid}, 32'd0);
    chk("t5_rst_addr", mem_addr, 32'd0);
    chk("t5_rst_rdata", ifu_rdata, 32'd0);
    step();
    rst = 1'b0; mem_resp_valid = 1'b0; #1;
    chk("t5_post_grant", {31'd0, ifu_req_ready}, 32'd1);
    step();
    ifu_req_valid = 1'b0; #1;
    chk("t5_post_memv", {31'd0, mem_req_valid}, 32'd1);
    chk("t5_post_addr", mem_addr, 32'h8000_0200);
    step();
    mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0513; #1;
    chk("t5_post_resp", ifu_rdata, 32'h0000_0513);
    step();
    mem_resp_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
